// File: rtl/axis_hash_target_check.sv
// Word-serial 256-bit hash vs. difficulty target comparator.
// Emits a two-beat status/sequence packet per hash and counts hits.
module axis_hash_target_check #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int NUMBER_OF_HASH_WORDS = 8
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic [255:0]                        target,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic [15:0]                         hit_count
);

  typedef enum logic [1:0] {RECV = 2'd0, SEND_STATUS = 2'd1, SEND_SEQ = 2'd2} state_t;
  typedef enum logic [1:0] {UNDECIDED = 2'd0, LESS = 2'd1, GREATER = 2'd2} cmp_t;

  localparam logic [2:0] LAST_IDX = 3'(NUMBER_OF_HASH_WORDS - 1);

  state_t        state_r;
  cmp_t          cmp_r;
  cmp_t          cmp_next_s;
  logic [2:0]    cnt_r;
  logic [255:0]  target_q_r;
  logic [31:0]   status_r;
  logic [31:0]   status_s;
  logic [31:0]   seq_num_r;
  logic [15:0]   hit_count_r;
  logic [15:0]   hit_count_next_s;
  logic          s_tready_r;
  logic          m_tvalid_r;
  logic          m_tlast_r;
  logic [31:0]   m_tdata_r;
  logic [31:0]   tgt_word_s;
  logic          beat_s;
  logic          last_beat_s;
  logic          short_s;
  logic          no_tlast_s;
  logic          hit_s;
  logic          unused_s;

  assign unused_s      = ^S_AXIS_TSTRB;
  assign beat_s        = S_AXIS_TVALID && s_tready_r;
  assign S_AXIS_TREADY = s_tready_r;
  assign M_AXIS_TVALID = m_tvalid_r;
  assign M_AXIS_TLAST  = m_tlast_r;
  assign M_AXIS_TDATA  = m_tdata_r;
  assign M_AXIS_TSTRB  = 4'hF;
  assign hit_count     = hit_count_r;

  // Select the target word for the current beat; word 0 comes straight from the port.
  always_comb begin
    tgt_word_s = 32'd0;
    case (cnt_r)
      3'd0:    tgt_word_s = target[255:224];
      3'd1:    tgt_word_s = target_q_r[223:192];
      3'd2:    tgt_word_s = target_q_r[191:160];
      3'd3:    tgt_word_s = target_q_r[159:128];
      3'd4:    tgt_word_s = target_q_r[127:96];
      3'd5:    tgt_word_s = target_q_r[95:64];
      3'd6:    tgt_word_s = target_q_r[63:32];
      3'd7:    tgt_word_s = target_q_r[31:0];
      default: tgt_word_s = target[255:224];
    endcase
  end

  // The first differing word decides the result; later words cannot change it.
  always_comb begin
    cmp_next_s = cmp_r;
    if (cmp_r == UNDECIDED) begin
      if (S_AXIS_TDATA < tgt_word_s) begin
        cmp_next_s = LESS;
      end else if (S_AXIS_TDATA > tgt_word_s) begin
        cmp_next_s = GREATER;
      end else begin
        cmp_next_s = UNDECIDED;
      end
    end else begin
      cmp_next_s = cmp_r;
    end
  end

  // Packet-end classification and status word assembly.
  always_comb begin
    last_beat_s = S_AXIS_TLAST || (cnt_r == LAST_IDX);
    short_s     = S_AXIS_TLAST && (cnt_r != LAST_IDX);
    no_tlast_s  = !S_AXIS_TLAST && (cnt_r == LAST_IDX);
    hit_s       = (cmp_next_s == LESS) && !short_s;
    status_s    = {20'd0, ({1'b0, cnt_r} + 4'd1), 5'd0, no_tlast_s, short_s, hit_s};
    if (hit_count_r == 16'hFFFF) begin
      hit_count_next_s = hit_count_r;
    end else begin
      hit_count_next_s = hit_count_r + 16'd1;
    end
  end

  // Receive / send-status / send-sequence state machine with registered stream outputs.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_r     <= RECV;
      cmp_r       <= UNDECIDED;
      cnt_r       <= 3'd0;
      target_q_r  <= 256'd0;
      status_r    <= 32'd0;
      seq_num_r   <= 32'd0;
      hit_count_r <= 16'd0;
      s_tready_r  <= 1'b1;
      m_tvalid_r  <= 1'b0;
      m_tlast_r   <= 1'b0;
      m_tdata_r   <= 32'd0;
    end else begin
      case (state_r)
        RECV: begin
          if (beat_s) begin
            if (cnt_r == 3'd0) begin
              target_q_r <= target;
            end
            if (last_beat_s) begin
              status_r   <= status_s;
              m_tdata_r  <= status_s;
              m_tvalid_r <= 1'b1;
              m_tlast_r  <= 1'b0;
              s_tready_r <= 1'b0;
              cnt_r      <= 3'd0;
              cmp_r      <= UNDECIDED;
              state_r    <= SEND_STATUS;
            end else begin
              cnt_r <= cnt_r + 3'd1;
              cmp_r <= cmp_next_s;
            end
          end
        end
        SEND_STATUS: begin
          if (M_AXIS_TREADY) begin
            m_tdata_r <= seq_num_r;
            m_tlast_r <= 1'b1;
            state_r   <= SEND_SEQ;
          end
        end
        SEND_SEQ: begin
          if (M_AXIS_TREADY) begin
            seq_num_r <= seq_num_r + 32'd1;
            if (status_r[0]) begin
              hit_count_r <= hit_count_next_s;
            end
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tdata_r  <= 32'd0;
            s_tready_r <= 1'b1;
            state_r    <= RECV;
          end
        end
        default: begin
          state_r    <= RECV;
          cmp_r      <= UNDECIDED;
          cnt_r      <= 3'd0;
          s_tready_r <= 1'b1;
          m_tvalid_r <= 1'b0;
          m_tlast_r  <= 1'b0;
          m_tdata_r  <= 32'd0;
        end
      endcase
    end
  end

endmodule
